burst_coalescer: RTL

- Parametrised successor of the back-end burst storage stage.
- Sits between the banks arbiter and the timing controller/PHY data path.
- Coalesces single-beat requests into NUM_BURSTS burst slots, each BURST_LEN beats. A slot is keyed by burst address and type.
- Tracks each slot through fill → issue → data transfer → return, then drains completed beats to the returner over a valid/ready handshake.
- Adds three behaviours: backpressure, idle-timeout burst closing, and a locked in-order return.

---
 rtl/burst_coalescer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/burst_coalescer.sv
// burst_coalescer: coalesces single-beat requests into keyed burst slots and drains completed bursts in order
module burst_coalescer #(
  parameter int NUM_BURSTS = 4,
  parameter int BURST_LEN = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W = 7,
  parameter int KEY_W = 26,
  parameter int CLOSE_TIMEOUT = 8,
  localparam int SW = $clog2(NUM_BURSTS),
  localparam int BW = $clog2(BURST_LEN),
  localparam int FW = $clog2(NUM_BURSTS) + 1,
  localparam int TW = $clog2(CLOSE_TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [KEY_W-1:0]             req_key,
  input  logic [BW-1:0]                req_beat,
  input  logic                         req_type,
  input  logic [DATA_W-1:0]            req_data,
  input  logic [IDX_W-1:0]             req_index,
  output logic [3*NUM_BURSTS-1:0]      slot_state,
  output logic [KEY_W*NUM_BURSTS-1:0]  slot_key,
  output logic [NUM_BURSTS-1:0]        slot_type,
  output logic [BURST_LEN*NUM_BURSTS-1:0] slot_mask,
  output logic [FW-1:0]                free_count,
  input  logic                         issue_valid,
  input  logic [SW-1:0]                issue_slot,
  input  logic                         beat_valid,
  input  logic [SW-1:0]                beat_slot,
  input  logic [DATA_W-1:0]            beat_rdata,
  output logic [DATA_W-1:0]            beat_wdata,
  output logic                         beat_wmask,
  output logic                         ret_valid,
  input  logic                         ret_ready,
  output logic                         ret_type,
  output logic [DATA_W-1:0]            ret_data,
  output logic [IDX_W-1:0]             ret_index
);
  localparam logic [2:0] EMPTY = 3'd0, FILLING = 3'd1, FULL = 3'd2, ISSUED = 3'd3, RETURNING = 3'd4;
  logic [2:0] st [NUM_BURSTS];
  logic [2:0] st_n [NUM_BURSTS];
  logic [KEY_W-1:0] key [NUM_BURSTS];
  logic [NUM_BURSTS-1:0] typ;
  logic [BURST_LEN-1:0] mask [NUM_BURSTS];
  logic [BW-1:0] cnt [NUM_BURSTS];
  logic [DATA_W-1:0] data [NUM_BURSTS][BURST_LEN];
  logic [IDX_W-1:0] idx [NUM_BURSTS][BURST_LEN];
  logic open_v, lock_v, ret_any;
  logic [SW-1:0] open_s, lock_s, free_s, ret_s, wr_s;
  logic [TW-1:0] idle;
  logic [FW-1:0] fc_n;
  logic [BW-1:0] pb;
  logic [BURST_LEN-1:0] bsel, pbit;
  logic hit, acc, miss, close_full, timeout, pop, last_pop, iss, bt, bt_last;
  assign bsel = BURST_LEN'(1) << req_beat;
  assign pbit = BURST_LEN'(1) << pb;
  assign hit = open_v && key[open_s] == req_key && typ[open_s] == req_type && !mask[open_s][req_beat];
  assign req_ready = hit || free_count != '0;
  assign acc = req_valid && req_ready;
  assign miss = acc && !hit;
  assign wr_s = hit ? open_s : free_s;
  assign close_full = acc && hit && &(mask[open_s] | bsel);
  // Any accept restarts the idle window, so timeout only fires on a quiet cycle
  assign timeout = open_v && !acc && idle == TW'(CLOSE_TIMEOUT - 1);
  assign iss = issue_valid && st[issue_slot] == FULL;
  assign bt = beat_valid && st[beat_slot] == ISSUED && !(issue_valid && issue_slot == beat_slot);
  assign bt_last = bt && cnt[beat_slot] == BW'(BURST_LEN - 1);
  assign ret_valid = lock_v;
  assign pop = lock_v && ret_ready;
  assign last_pop = pop && (mask[lock_s] & ~pbit) == '0;
  assign ret_type = typ[lock_s];
  assign ret_data = data[lock_s][pb];
  assign ret_index = idx[lock_s][pb];
  assign beat_wdata = data[beat_slot][cnt[beat_slot]];
  assign beat_wmask = mask[beat_slot][cnt[beat_slot]];
  assign slot_type = typ;
  always_comb begin
    for (int i = 0; i < NUM_BURSTS; i++) st_n[i] = st[i];
    if (open_v && (miss || close_full || timeout)) st_n[open_s] = FULL;
    if (miss) st_n[free_s] = FILLING;
    if (iss) st_n[issue_slot] = ISSUED;
    if (bt_last) st_n[beat_slot] = RETURNING;
    if (last_pop) st_n[lock_s] = EMPTY;
  end
  always_comb begin
    free_s = '0;
    ret_s = '0;
    ret_any = 1'b0;
    fc_n = '0;
    pb = '0;
    for (int i = NUM_BURSTS - 1; i >= 0; i--) begin
      if (st[i] == EMPTY) free_s = SW'(i);
      if (st[i] == RETURNING) begin
        ret_any = 1'b1;
        ret_s = SW'(i);
      end
      fc_n = fc_n + FW'(st_n[i] == EMPTY);
    end
    for (int j = BURST_LEN - 1; j >= 0; j--) if (mask[lock_s][j]) pb = BW'(j);
  end
  always_comb begin
    slot_state = '0;
    slot_key = '0;
    slot_mask = '0;
    for (int i = 0; i < NUM_BURSTS; i++) begin
      slot_state[3*i +: 3] = st[i];
      slot_key[KEY_W*i +: KEY_W] = key[i];
      slot_mask[BURST_LEN*i +: BURST_LEN] = mask[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BURSTS; i++) begin
        st[i] <= EMPTY;
        key[i] <= '0;
        mask[i] <= '0;
        cnt[i] <= '0;
      end
      typ <= '0;
      open_v <= 1'b0;
      open_s <= '0;
      idle <= '0;
      lock_v <= 1'b0;
      lock_s <= '0;
      free_count <= FW'(NUM_BURSTS);
    end else begin
      for (int i = 0; i < NUM_BURSTS; i++) st[i] <= st_n[i];
      free_count <= fc_n;
      idle <= (acc || timeout || !open_v) ? '0 : idle + 1'b1;
      if (miss) begin
        open_v <= 1'b1;
        open_s <= free_s;
        key[free_s] <= req_key;
        typ[free_s] <= req_type;
      end else if (close_full || timeout) open_v <= 1'b0;
      if (acc) begin
        idx[wr_s][req_beat] <= req_index;
        mask[wr_s] <= hit ? (mask[wr_s] | bsel) : bsel;
        if (req_type) data[wr_s][req_beat] <= req_data;
      end
      if (iss) cnt[issue_slot] <= '0;
      if (bt) begin
        cnt[beat_slot] <= cnt[beat_slot] + 1'b1;
        if (!typ[beat_slot] && mask[beat_slot][cnt[beat_slot]]) data[beat_slot][cnt[beat_slot]] <= beat_rdata;
      end
      if (pop) mask[lock_s] <= mask[lock_s] & ~pbit;
      if (last_pop) lock_v <= 1'b0;
      else if (!lock_v && ret_any) begin
        lock_v <= 1'b1;
        lock_s <= ret_s;
      end
    end
  end
endmodule
